frame_arbiter: RTL and testbench

Arbitrates one ZBT frame-buffer SRAM among three requesters: the VGA reader (reads), the NTSC capture writer and the projection writer. Issues at most one memory transaction per cycle through a fixed-latency pipeline. Double-buffers the frame: writers always target the back buffer, the VGA reader always streams the front buffer, and the two swap on `frame_flag`. Sits between the requester blocks and the ZBT pins.

---
 rtl/frame_arbiter_pkg.sv | 12 +
 rtl/frame_arbiter_zbt_pipe.sv | 42 ++++
 rtl/frame_arbiter.sv | 128 ++++++++++++
 tb/tb_frame_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_arbiter_pkg.sv
// Shared constants for the ZBT frame-buffer arbiter: requester IDs and default geometry.
package frame_arbiter_pkg;
    localparam int FRAME_WORDS = 153600;
    localparam int LATENCY     = 2;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_VGA  = 2'd1,
        REQ_NTSC = 2'd2,
        REQ_PROJ = 2'd3
    } req_id_t;
endpackage

// File: rtl/frame_arbiter_zbt_pipe.sv
// Fixed-latency shadow of the ZBT pipeline: carries {valid, requester, write data}
// so write data and read-return steering line up with the SRAM.
module zbt_pipe #(
    parameter int LATENCY   = 2,
    parameter int MEM_WIDTH = 36
) (
    input  logic                       clock,
    input  logic                       reset_b,
    input  logic                       in_valid,
    input  frame_arbiter_pkg::req_id_t in_id,
    input  logic [MEM_WIDTH-1:0]       in_data,
    output logic                       out_valid,
    output frame_arbiter_pkg::req_id_t out_id,
    output logic [MEM_WIDTH-1:0]       out_data
);
    import frame_arbiter_pkg::*;

    logic [LATENCY-1:0]                vld_pipe;
    logic [LATENCY-1:0][1:0]           id_pipe;
    logic [LATENCY-1:0][MEM_WIDTH-1:0] dat_pipe;

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            id_pipe[0]  <= in_id;
            dat_pipe[0] <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign out_valid = vld_pipe[LATENCY-1];
    assign out_id    = req_id_t'(id_pipe[LATENCY-1]);
    assign out_data  = dat_pipe[LATENCY-1];
endmodule

// File: rtl/frame_arbiter.sv
// Arbitrates the double-buffered ZBT frame buffer between the VGA reader and two writers.
// VGA wins outright; writers alternate; one outstanding transaction per requester.
module frame_arbiter #(
    parameter int MEM_WIDTH   = 36,
    parameter int ADDR_WIDTH  = 18,
    parameter int FRAME_WORDS = frame_arbiter_pkg::FRAME_WORDS,
    parameter int LATENCY     = frame_arbiter_pkg::LATENCY
) (
    input  logic                  clock,
    input  logic                  reset_b,
    input  logic                  frame_flag,
    input  logic                  vga_flag,
    output logic [MEM_WIDTH-1:0]  vga_pixel,
    output logic                  done_vga,
    input  logic                  ntsc_flag,
    input  logic [ADDR_WIDTH-1:0] ntsc_addr,
    input  logic [MEM_WIDTH-1:0]  ntsc_pixel,
    output logic                  done_ntsc,
    input  logic                  proj_flag,
    input  logic [ADDR_WIDTH-1:0] proj_addr,
    input  logic [MEM_WIDTH-1:0]  proj_pixel,
    output logic                  done_proj,
    output logic [ADDR_WIDTH:0]   mem_addr,
    output logic                  mem_we,
    output logic [MEM_WIDTH-1:0]  mem_din,
    input  logic [MEM_WIDTH-1:0]  mem_dout
);
    import frame_arbiter_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FRAME_WORDS - 1);

    logic                  display_sel, frame_flag_d, rr_proj;
    logic                  vga_pend, ntsc_pend, proj_pend;
    logic                  vga_ok, ntsc_ok, proj_ok;
    logic [ADDR_WIDTH-1:0] vga_cnt, wr_addr;
    logic [MEM_WIDTH-1:0]  wr_data, pipe_data;
    logic                  ret_valid;
    req_id_t               gnt, ret_id;

    assign vga_ok  = vga_flag  & ~vga_pend  & ~frame_flag;
    assign ntsc_ok = ntsc_flag & ~ntsc_pend & ~frame_flag;
    assign proj_ok = proj_flag & ~proj_pend & ~frame_flag;

    always_comb begin
        gnt = REQ_NONE;
        if (vga_ok)                gnt = REQ_VGA;
        else if (ntsc_ok && proj_ok) gnt = rr_proj ? REQ_PROJ : REQ_NTSC;
        else if (ntsc_ok)          gnt = REQ_NTSC;
        else if (proj_ok)          gnt = REQ_PROJ;
    end

    assign wr_addr   = (gnt == REQ_PROJ) ? proj_addr  : ntsc_addr;
    assign wr_data   = (gnt == REQ_PROJ) ? proj_pixel : ntsc_pixel;
    assign pipe_data = (gnt == REQ_NTSC || gnt == REQ_PROJ) ? wr_data : '0;

    zbt_pipe #(.LATENCY(LATENCY), .MEM_WIDTH(MEM_WIDTH)) u_pipe (
        .clock     (clock),
        .reset_b   (reset_b),
        .in_valid  (gnt != REQ_NONE),
        .in_id     (gnt),
        .in_data   (pipe_data),
        .out_valid (ret_valid),
        .out_id    (ret_id),
        .out_data  (mem_din)
    );

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            display_sel  <= 1'b0;
            frame_flag_d <= 1'b0;
            rr_proj      <= 1'b0;
            vga_pend     <= 1'b0;
            ntsc_pend    <= 1'b0;
            proj_pend    <= 1'b0;
            vga_cnt      <= '0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            done_ntsc    <= 1'b0;
            done_proj    <= 1'b0;
            done_vga     <= 1'b0;
            vga_pixel    <= '0;
        end else begin
            frame_flag_d <= frame_flag;
            mem_we       <= 1'b0;
            done_ntsc    <= 1'b0;
            done_proj    <= 1'b0;
            done_vga     <= 1'b0;

            // A requester stays blocked until its done pulse has been seen.
            if (done_vga)  vga_pend  <= 1'b0;
            if (done_ntsc) ntsc_pend <= 1'b0;
            if (done_proj) proj_pend <= 1'b0;

            if (frame_flag && !frame_flag_d) begin
                display_sel <= ~display_sel;
                vga_cnt     <= '0;
            end

            case (gnt)
                REQ_VGA: begin
                    mem_addr <= {display_sel, vga_cnt};
                    vga_cnt  <= (vga_cnt == LAST_WORD) ? '0 : vga_cnt + 1'b1;
                    vga_pend <= 1'b1;
                end
                REQ_NTSC, REQ_PROJ: begin
                    // Out-of-range writes are acknowledged but never reach the SRAM.
                    mem_addr <= {~display_sel, wr_addr};
                    mem_we   <= (wr_addr <= LAST_WORD);
                    if (gnt == REQ_NTSC) begin
                        done_ntsc <= 1'b1;
                        ntsc_pend <= 1'b1;
                        rr_proj   <= 1'b1;
                    end else begin
                        done_proj <= 1'b1;
                        proj_pend <= 1'b1;
                        rr_proj   <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (ret_valid && ret_id == REQ_VGA) begin
                vga_pixel <= mem_dout;
                done_vga  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_frame_arbiter.sv
// Bench for frame_arbiter: echo SRAM, cycle-level reference model, directed and random traffic.
module tb_frame_arbiter;
    localparam int MW = 36;
    localparam int AW = 18;
    localparam int FW = 153600;
    localparam int L  = 2;

    logic          clock = 0, reset_b = 0, frame_flag = 0;
    logic          vga_flag = 0, ntsc_flag = 0, proj_flag = 0;
    logic [AW-1:0] ntsc_addr = '0, proj_addr = '0;
    logic [MW-1:0] ntsc_pixel = '0, proj_pixel = '0, mem_dout = '0;
    logic [MW-1:0] vga_pixel, mem_din;
    logic          done_vga, done_ntsc, done_proj, mem_we;
    logic [AW:0]   mem_addr;

    int errors = 0;
    int checks = 0;

    frame_arbiter dut (
        .clock(clock), .reset_b(reset_b), .frame_flag(frame_flag),
        .vga_flag(vga_flag), .vga_pixel(vga_pixel), .done_vga(done_vga),
        .ntsc_flag(ntsc_flag), .ntsc_addr(ntsc_addr), .ntsc_pixel(ntsc_pixel), .done_ntsc(done_ntsc),
        .proj_flag(proj_flag), .proj_addr(proj_addr), .proj_pixel(proj_pixel), .done_proj(done_proj),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;

    // SRAM stand-in: read data is the address itself, one cycle after the address cycle.
    always @(posedge clock) mem_dout <= {{(MW-AW-1){1'b0}}, mem_addr};

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each requester is free again a fixed number of edges after its grant.
    int            cyc = 0;
    bit            m_sel, m_ffd, m_rr;
    int            m_cnt, v_next, n_next, p_next;
    logic [MW-1:0] din_at[int];
    logic [MW-1:0] ret_at[int];
    logic [AW:0]   e_addr;
    logic          e_we, e_dn, e_dp, e_dv;
    logic [MW-1:0] e_din, e_pix, wd;
    logic [AW-1:0] wa;
    bit            v_ok, n_ok, p_ok, pick_n, pick_p;

    always @(posedge clock) begin
        cyc++;
        if (!reset_b) begin
            m_sel = 0; m_ffd = 0; m_rr = 0; m_cnt = 0;
            v_next = 0; n_next = 0; p_next = 0;
            din_at.delete(); ret_at.delete();
            e_addr = '0; e_we = 0; e_dn = 0; e_dp = 0; e_dv = 0; e_din = '0; e_pix = '0;
        end else begin
            e_dv = ret_at.exists(cyc);
            if (e_dv) begin
                e_pix = ret_at[cyc];
                ret_at.delete(cyc);
            end
            e_din = '0;
            if (din_at.exists(cyc)) begin
                e_din = din_at[cyc];
                din_at.delete(cyc);
            end
            e_we = 0; e_dn = 0; e_dp = 0;
            v_ok   = vga_flag  && !frame_flag && cyc >= v_next;
            n_ok   = ntsc_flag && !frame_flag && cyc >= n_next;
            p_ok   = proj_flag && !frame_flag && cyc >= p_next;
            pick_n = n_ok && (!p_ok || !m_rr);
            pick_p = p_ok && !pick_n;
            if (v_ok) begin
                e_addr = {m_sel, AW'(m_cnt)};
                ret_at[cyc+L] = MW'({m_sel, AW'(m_cnt)});
                v_next = cyc + L + 2;
                m_cnt  = (m_cnt + 1) % FW;
            end else if (pick_n || pick_p) begin
                wa = pick_n ? ntsc_addr  : proj_addr;
                wd = pick_n ? ntsc_pixel : proj_pixel;
                e_addr = {~m_sel, wa};
                e_we   = (int'(wa) < FW);
                din_at[cyc+L-1] = wd;
                if (pick_n) begin e_dn = 1; n_next = cyc + 2; m_rr = 1; end
                else        begin e_dp = 1; p_next = cyc + 2; m_rr = 0; end
            end
            if (frame_flag && !m_ffd) begin
                m_sel = !m_sel;
                m_cnt = 0;
            end
            m_ffd = frame_flag;
        end
        #1;
        check("mem_addr",  mem_addr,  e_addr);
        check("mem_we",    mem_we,    e_we);
        check("mem_din",   mem_din,   e_din);
        check("done_ntsc", done_ntsc, e_dn);
        check("done_proj", done_proj, e_dp);
        check("done_vga",  done_vga,  e_dv);
        check("vga_pixel", vga_pixel, e_pix);
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_done_vga(output logic [MW-1:0] px);
        bit got = 0;
        px = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (done_vga) begin
                px  = vga_pixel;
                got = 1;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL wait_done_vga: got timeout expected done_vga at %0t", $time);
        end
    endtask

    task automatic wait_addr(input logic [AW:0] a);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (mem_addr == a) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL wait_addr: got %h expected %h at %0t", mem_addr, a, $time);
        end
    endtask

    logic [MW-1:0] px;
    int            last_w, bad, wcnt;
    bit            seen;

    initial begin
        tick(); tick();
        check("reset_ctl", MW'({mem_addr, mem_we, done_vga, done_ntsc, done_proj}), '0);
        check("reset_pix", vga_pixel, '0);
        check("reset_din", mem_din, '0);
        reset_b = 1;

        // VGA stream from address 0, then a frame swap with the fourth read in flight.
        vga_flag = 1;
        for (int k = 0; k < 3; k++) begin
            wait_done_vga(px);
            check("vga_stream", px, MW'(k));
        end
        wait_addr(19'd3);
        frame_flag = 1; ntsc_flag = 1; ntsc_addr = 18'd5;
        tick();
        check("frame_no_grant", done_ntsc, 1'b0);
        check("frame_addr_hold", mem_addr, 19'd3);
        frame_flag = 0; ntsc_flag = 0;
        wait_done_vga(px);
        check("inflight_old_bank", px, 36'd3);
        wait_done_vga(px);
        check("swap_new_bank", px, 36'h40000);

        // Reset in the middle of a read.
        wait_addr(19'h40001);
        #2 reset_b = 0;
        #1;
        check("rst_async_pix", vga_pixel, '0);
        check("rst_async_ctl", MW'({mem_addr, mem_we, done_vga, done_ntsc, done_proj}), '0);
        vga_flag = 0;
        tick(); tick();
        reset_b = 1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done_vga) seen = 1;
        end
        check("no_done_after_reset", seen, 1'b0);

        // Write data lag into the back buffer.
        proj_flag = 1; proj_addr = 18'h100; proj_pixel = 36'hABCDE;
        tick();
        check("wr_we", mem_we, 1'b1);
        check("wr_addr", mem_addr, 19'h40100);
        check("wr_done", done_proj, 1'b1);
        proj_flag = 0;
        tick();
        check("wr_din", mem_din, 36'hABCDE);
        check("wr_done_once", done_proj, 1'b0);

        // Out-of-range write is acknowledged without a write strobe.
        ntsc_flag = 1; ntsc_addr = 18'd153600; ntsc_pixel = 36'h1;
        tick();
        check("oor_done", done_ntsc, 1'b1);
        check("oor_we", mem_we, 1'b0);
        ntsc_flag = 0;
        tick();

        // Full contention: writers must alternate around VGA.
        vga_flag = 1; ntsc_flag = 1; proj_flag = 1;
        last_w = -1; bad = 0; wcnt = 0;
        for (int i = 0; i < 40; i++) begin
            ntsc_addr = AW'($urandom_range(0, FW-1));
            proj_addr = AW'($urandom_range(0, FW-1));
            tick();
            if (done_ntsc && done_proj) bad++;
            else if (done_ntsc) begin if (last_w == 0) bad++; last_w = 0; wcnt++; end
            else if (done_proj) begin if (last_w == 1) bad++; last_w = 1; wcnt++; end
        end
        check("writer_alternate", MW'(bad), '0);
        check("writer_share", (wcnt >= 20), 1'b1);
        vga_flag = 0; ntsc_flag = 0; proj_flag = 0;
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            vga_flag   = ($urandom_range(0, 3) != 0);
            ntsc_flag  = $urandom_range(0, 1) == 1;
            proj_flag  = $urandom_range(0, 1) == 1;
            ntsc_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(FW, 2**AW-1))
                                                     : AW'($urandom_range(0, FW-1));
            proj_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(FW, 2**AW-1))
                                                     : AW'($urandom_range(0, FW-1));
            ntsc_pixel = MW'({$urandom(), $urandom()});
            proj_pixel = MW'({$urandom(), $urandom()});
            frame_flag = ($urandom_range(0, 29) == 0);
            reset_b    = ($urandom_range(0, 799) != 0);
            tick();
        end
        reset_b = 1; vga_flag = 0; ntsc_flag = 0; proj_flag = 0; frame_flag = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
